load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lsu_align.sv | 53 +++++
 rtl/load_store_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, RV32I funct3 codes
// and the legality/alignment rule applied before any memory request.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_REQ   = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  // True when the access may go to memory: legal funct3 and naturally aligned.
  function automatic logic access_ok(input logic is_store, input logic [2:0] f3,
                                     input logic [1:0] addr_lo);
    logic legal;
    logic aligned;
    if (is_store) legal = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    else legal = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                 (f3 == F3_LBU) || (f3 == F3_LHU);
    case (f3[1:0])
      2'd1:    aligned = ~addr_lo[0];
      2'd2:    aligned = (addr_lo == 2'b00);
      default: aligned = 1'b1;
    endcase
    return legal & aligned;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store data replication and byte enables, plus load lane
// extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] mem_rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] store_data_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    be_o         = 4'hF;
    store_data_o = wdata_i;
    if (is_store_i) begin
      case (funct3_i[1:0])
        2'd0: begin
          be_o         = 4'b0001 << addr_lo_i;
          store_data_o = {4{wdata_i[7:0]}};
        end
        2'd1: begin
          be_o         = 4'b0011 << {addr_lo_i[1], 1'b0};
          store_data_o = {2{wdata_i[15:0]}};
        end
        default: begin
          be_o         = 4'hF;
          store_data_o = wdata_i;
        end
      endcase
    end
  end

  always_comb begin
    byte_lane   = mem_rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_lane   = addr_lo_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    load_data_o = mem_rdata_i;
    case (funct3_i)
      F3_LB:   load_data_o = {{24{byte_lane[7]}}, byte_lane};
      F3_LH:   load_data_o = {{16{half_lane[15]}}, half_lane};
      F3_LBU:  load_data_o = {24'h0, byte_lane};
      F3_LHU:  load_data_o = {16'h0, half_lane};
      default: load_data_o = mem_rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: takes one access from the control unit, checks it, runs a
// req/ack memory handshake with timeout, and reports done/fault with load data.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  // Handshake: mem_req stays high with stable addr/we/be/wdata until mem_ack
  // is sampled high on a rising edge; mem_ack outside REQ is ignored.

  lsu_state_e  state_q, state_d;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q, wdata_q;
  logic        fault_q, fault_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  be;
  logic [31:0] store_data, load_data;
  logic        in_req;

  lsu_align u_align (
    .is_store_i   (is_store_q),
    .funct3_i     (funct3_q),
    .addr_lo_i    (addr_q[1:0]),
    .wdata_i      (wdata_q),
    .mem_rdata_i  (mem_rdata),
    .be_o         (be),
    .store_data_o (store_data),
    .load_data_o  (load_data)
  );

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    wait_d  = wait_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CHECK;
          fault_d = 1'b0;
        end
      end
      ST_CHECK: begin
        wait_d = 8'd0;
        if (access_ok(is_store_q, funct3_q, addr_q[1:0])) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_RESP;
          fault_d = 1'b1;
        end
      end
      ST_REQ: begin
        // An ack in the final allowed cycle still wins over the timeout.
        if (mem_ack) begin
          state_d = ST_RESP;
          if (!is_store_q) rdata_d = load_data;
        end else if (wait_q == 8'(MAX_WAIT - 1)) begin
          state_d = ST_RESP;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        wait_d  = 8'd0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      fault_q    <= 1'b0;
      wait_q     <= 8'd0;
      rdata_q    <= 32'h0;
      is_store_q <= 1'b0;
      funct3_q   <= 3'd0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      wait_q  <= wait_d;
      rdata_q <= rdata_d;
      if (state_q == ST_IDLE && start) begin
        is_store_q <= is_store;
        funct3_q   <= funct3;
        addr_q     <= addr;
        wdata_q    <= wdata;
      end
    end
  end

  assign in_req    = (state_q == ST_REQ);
  assign busy      = (state_q == ST_CHECK) || in_req;
  assign done      = (state_q == ST_RESP);
  assign fault     = done & fault_q;
  assign rdata     = rdata_q;
  assign mem_req   = in_req;
  assign mem_we    = in_req & is_store_q;
  assign mem_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_wdata = in_req ? store_data : 32'h0;
  assign mem_be    = in_req ? be : 4'h0;
  assign dbg_state = state_q;

endmodule
